// File: rtl/contingency_table_builder.sv
// Builds the 3x3x2 genotype-by-phenotype contingency table and sample count for one SNP pair
// from streamed one-hot bitplanes, then hands the result to the interaction-measure stage.
//
// state   | meaning
// IDLE    | waiting for start_in
// ACCUM   | accepting genotype words
// FLUSH   | draining the popcount pipeline after the last word
// WAIT_DS | result ready, waiting for the downstream stage to go idle
// EMIT    | one-cycle result pulse
module contingency_table_builder #(
   parameter int DATA_WIDTH = 16,
   parameter int WORD_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_in,
   input  logic                      word_valid_in,
   input  logic                      word_last_in,
   input  logic                      word_class_in,
   input  logic [3*WORD_WIDTH-1:0]   a_geno_in,
   input  logic [3*WORD_WIDTH-1:0]   b_geno_in,
   output logic                      ready_out,
   input  logic                      downstream_busy_in,
   output logic [18*DATA_WIDTH-1:0]  joint_table_out,
   output logic [DATA_WIDTH-1:0]     n_out,
   output logic                      data_valid_out,
   output logic                      overflow_out,
   output logic                      busy_out
);

   localparam int PCW = $clog2(WORD_WIDTH) + 1;
   localparam int SW  = ((DATA_WIDTH > PCW) ? DATA_WIDTH : PCW) + 5;
   localparam logic [SW-1:0] MAX_CNT = (SW'(1) << DATA_WIDTH) - SW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_FLUSH,
      S_WAIT_DS,
      S_EMIT
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WORD_WIDTH-1:0] w_a_clean [3];
   logic [WORD_WIDTH-1:0] w_b_clean [3];
   logic [PCW-1:0]        w_pc      [9];
   logic                  w_accept;
   logic                  w_load;

   logic [PCW-1:0]        r_pc      [9];
   logic                  r_s1_valid;
   logic                  r_s1_class;

   logic [DATA_WIDTH-1:0] r_acc     [18];
   logic [DATA_WIDTH-1:0] r_n;
   logic                  r_ovf;

   logic [DATA_WIDTH-1:0] w_acc_nxt [18];
   logic [DATA_WIDTH-1:0] w_n_nxt;
   logic                  w_sat;
   logic [SW-1:0]         w_sum;
   logic [SW-1:0]         w_nsum;

   logic [18*DATA_WIDTH-1:0] r_table_out;
   logic [DATA_WIDTH-1:0]    r_n_out;
   logic                     r_ovf_out;

   function automatic logic [PCW-1:0] popcnt(input logic [WORD_WIDTH-1:0] v);
      logic [PCW-1:0] c;
      c = '0;
      for (int b = 0; b < WORD_WIDTH; b++) begin
         c = c + PCW'(v[b]);
      end
      return c;
   endfunction

   assign w_accept = word_valid_in && (r_state == S_ACCUM);
   assign w_load   = (r_state == S_WAIT_DS) && !downstream_busy_in;

   // A sample bit survives only if exactly one plane is set for that SNP.
   always_comb begin
      for (int g = 0; g < 3; g++) begin
         w_a_clean[g] = a_geno_in[g*WORD_WIDTH +: WORD_WIDTH]
                      & ~a_geno_in[((g+1)%3)*WORD_WIDTH +: WORD_WIDTH]
                      & ~a_geno_in[((g+2)%3)*WORD_WIDTH +: WORD_WIDTH];
         w_b_clean[g] = b_geno_in[g*WORD_WIDTH +: WORD_WIDTH]
                      & ~b_geno_in[((g+1)%3)*WORD_WIDTH +: WORD_WIDTH]
                      & ~b_geno_in[((g+2)%3)*WORD_WIDTH +: WORD_WIDTH];
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            w_pc[i*3+j] = popcnt(w_a_clean[i] & w_b_clean[j]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_class <= 1'b0;
         for (int p = 0; p < 9; p++) r_pc[p] <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_class <= word_class_in;
            for (int p = 0; p < 9; p++) r_pc[p] <= w_pc[p];
         end
      end
   end

   // Saturating accumulation; only the tagged class's nine cells move.
   always_comb begin
      w_sat  = 1'b0;
      w_sum  = '0;
      w_nsum = SW'(r_n);
      for (int c = 0; c < 18; c++) begin
         w_acc_nxt[c] = r_acc[c];
         w_sum        = SW'(r_acc[c]) + SW'(r_pc[c%9]);
         if (r_s1_valid && (r_s1_class == (c >= 9))) begin
            if (w_sum > MAX_CNT) begin
               w_acc_nxt[c] = '1;
               w_sat        = 1'b1;
            end else begin
               w_acc_nxt[c] = w_sum[DATA_WIDTH-1:0];
            end
         end
      end
      for (int p = 0; p < 9; p++) begin
         w_nsum = w_nsum + SW'(r_pc[p]);
      end
      w_n_nxt = r_n;
      if (r_s1_valid) begin
         if (w_nsum > MAX_CNT) begin
            w_n_nxt = '1;
            w_sat   = 1'b1;
         end else begin
            w_n_nxt = w_nsum[DATA_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || ((r_state == S_IDLE) && start_in)) begin
         for (int c = 0; c < 18; c++) r_acc[c] <= '0;
         r_n   <= '0;
         r_ovf <= 1'b0;
      end else if (r_s1_valid) begin
         for (int c = 0; c < 18; c++) r_acc[c] <= w_acc_nxt[c];
         r_n <= w_n_nxt;
         if (w_sat) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_table_out <= '0;
         r_n_out     <= '0;
         r_ovf_out   <= 1'b0;
      end else if (w_load) begin
         for (int c = 0; c < 18; c++) r_table_out[c*DATA_WIDTH +: DATA_WIDTH] <= r_acc[c];
         r_n_out   <= r_n;
         r_ovf_out <= r_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      ready_out      = 1'b0;
      busy_out       = 1'b1;
      data_valid_out = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy_out = 1'b0;
            if (start_in) w_state_nxt = S_ACCUM;
         end
         S_ACCUM: begin
            ready_out = 1'b1;
            if (word_valid_in && word_last_in) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            // Stage 1 empty means stage 2 has absorbed the last word.
            if (!r_s1_valid) w_state_nxt = S_WAIT_DS;
         end
         S_WAIT_DS: begin
            if (!downstream_busy_in) w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            data_valid_out = 1'b1;
            w_state_nxt    = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign joint_table_out = r_table_out;
   assign n_out           = r_n_out;
   assign overflow_out    = r_ovf_out;

endmodule

// File: tb/tb_contingency_table_builder.sv
// Directed bench for contingency_table_builder: a 16-bit instance for the main checks and an
// 8-bit instance sharing the same stimulus for saturation.
module tb_contingency_table_builder;

   localparam int DW  = 16;
   localparam int SDW = 8;
   localparam int WW  = 64;

   logic clk = 1'b0;
   logic rst, start_in, word_valid_in, word_last_in, word_class_in, downstream_busy_in;
   logic [3*WW-1:0] a_geno_in, b_geno_in;

   logic ready, dv, ovf, busy;
   logic [18*DW-1:0] tbl;
   logic [DW-1:0]    n;
   logic s_ready, s_dv, s_ovf, s_busy;
   logic [18*SDW-1:0] s_tbl;
   logic [SDW-1:0]    s_n;

   always #5 clk = ~clk;

   contingency_table_builder #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) u_dut (
      .clk(clk), .rst(rst), .start_in(start_in), .word_valid_in(word_valid_in),
      .word_last_in(word_last_in), .word_class_in(word_class_in),
      .a_geno_in(a_geno_in), .b_geno_in(b_geno_in), .ready_out(ready),
      .downstream_busy_in(downstream_busy_in), .joint_table_out(tbl), .n_out(n),
      .data_valid_out(dv), .overflow_out(ovf), .busy_out(busy));

   contingency_table_builder #(.DATA_WIDTH(SDW), .WORD_WIDTH(WW)) u_sat (
      .clk(clk), .rst(rst), .start_in(start_in), .word_valid_in(word_valid_in),
      .word_last_in(word_last_in), .word_class_in(word_class_in),
      .a_geno_in(a_geno_in), .b_geno_in(b_geno_in), .ready_out(s_ready),
      .downstream_busy_in(downstream_busy_in), .joint_table_out(s_tbl), .n_out(s_n),
      .data_valid_out(s_dv), .overflow_out(s_ovf), .busy_out(s_busy));

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct {
      logic [3*WW-1:0] a;
      logic [3*WW-1:0] b;
      logic            cls;
      int              i1;
      int              v1;
      int              i2;
      int              v2;
      int              n;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [18*DW-1:0] mk_tbl(input int i1, input int v1, input int i2, input int v2);
      logic [18*DW-1:0] t;
      t = '0;
      if (i1 >= 0) t[i1*DW +: DW] = DW'(v1);
      if (i2 >= 0) t[i2*DW +: DW] = DW'(v2);
      return t;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic start_pair();
      start_in = 1'b1;
      @(posedge clk);
      #1 start_in = 1'b0;
   endtask

   task automatic send_word(input logic [3*WW-1:0] a, input logic [3*WW-1:0] b,
                            input logic cls, input logic last);
      a_geno_in     = a;
      b_geno_in     = b;
      word_class_in = cls;
      word_last_in  = last;
      word_valid_in = 1'b1;
      @(posedge clk);
      #1;
      word_valid_in = 1'b0;
      word_last_in  = 1'b0;
   endtask

   task automatic wait_dv(output int lat);
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (dv) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) chk("dv_timeout", 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bad_dv, bad_busy, bad_hold;
      logic [18*DW-1:0]  prev_tbl;
      logic [DW-1:0]     prev_n;
      logic [18*SDW-1:0] s_exp;
      logic [63:0] ones;

      ones = '1;
      vecs[0] = '{a: {64'h0, 64'h0, ones}, b: {64'h0, ones, 64'h0}, cls: 1'b0,
                  i1: 1, v1: 64, i2: -1, v2: 0, n: 64};
      vecs[1] = '{a: {64'h0, 64'h1F, 64'hFFF}, b: {64'h0, 64'h0, 64'hF1F}, cls: 1'b0,
                  i1: 0, v1: 4, i2: -1, v2: 0, n: 4};
      vecs[2] = '{a: {64'hFFFFFFFF00000000, 64'h0, 64'h0}, b: {64'hFFFFFFFF00000000, 64'h0, 64'h0},
                  cls: 1'b1, i1: 17, v1: 32, i2: -1, v2: 0, n: 32};
      vecs[3] = '{a: {64'h0, 64'hFF, 64'h0}, b: {64'h0, 64'h0, 64'hFF}, cls: 1'b1,
                  i1: 12, v1: 8, i2: -1, v2: 0, n: 8};
      vecs[4] = '{a: '0, b: '0, cls: 1'b0, i1: -1, v1: 0, i2: -1, v2: 0, n: 0};
      vecs[5] = '{a: {64'h0, 64'hFFFF0000, 64'h0000FFFF}, b: {64'hFFFFFFFF, 64'h0, 64'h0},
                  cls: 1'b0, i1: 2, v1: 16, i2: 5, v2: 16, n: 32};

      start_in = 0; word_valid_in = 0; word_last_in = 0; word_class_in = 0;
      downstream_busy_in = 0; a_geno_in = '0; b_geno_in = '0;
      do_reset();

      chk("rst_ready", ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dv", dv, 0);
      chk("rst_table", tbl, 0);
      chk("rst_n", n, 0);
      chk("rst_ovf", ovf, 0);

      for (int v = 0; v < 6; v++) begin
         start_pair();
         chk($sformatf("v%0d_ready", v), ready, 1);
         chk($sformatf("v%0d_busy", v), busy, 1);
         send_word(vecs[v].a, vecs[v].b, vecs[v].cls, 1'b1);
         chk($sformatf("v%0d_ready_drop", v), ready, 0);
         wait_dv(lat);
         chk($sformatf("v%0d_latency", v), lat, 3);
         chk($sformatf("v%0d_table", v), tbl, mk_tbl(vecs[v].i1, vecs[v].v1, vecs[v].i2, vecs[v].v2));
         chk($sformatf("v%0d_n", v), n, vecs[v].n);
         chk($sformatf("v%0d_ovf", v), ovf, 0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_dv_once", v), dv, 0);
         chk($sformatf("v%0d_busy_fall", v), busy, 0);
      end

      // Two-word pair, with words offered in IDLE that must not be counted.
      a_geno_in = {64'h0, 64'h0, ones}; b_geno_in = {64'h0, 64'h0, ones};
      word_class_in = 0; word_last_in = 1; word_valid_in = 1;
      repeat (2) @(posedge clk);
      #1 word_valid_in = 0; word_last_in = 0;
      chk("idle_words_ignored", busy, 0);
      start_pair();
      send_word({64'h3FF, 64'h0, 64'h0}, {64'h0, 64'h0, 64'h3FF}, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      send_word({64'h0, 64'h7F, 64'h0}, {64'h7F, 64'h0, 64'h0}, 1'b1, 1'b1);
      wait_dv(lat);
      chk("two_table", tbl, mk_tbl(6, 10, 14, 7));
      chk("two_n", n, 17);
      @(posedge clk);
      #1;

      // Backpressure: result must wait while the calculator is busy.
      prev_tbl = tbl;
      prev_n   = n;
      downstream_busy_in = 1;
      start_pair();
      send_word(vecs[0].a, vecs[0].b, 1'b0, 1'b1);
      bad_dv = 0; bad_busy = 0; bad_hold = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (dv) bad_dv++;
         if (!busy) bad_busy++;
         if (tbl !== prev_tbl || n !== prev_n) bad_hold++;
      end
      chk("bp_no_dv", bad_dv, 0);
      chk("bp_busy_high", bad_busy, 0);
      chk("bp_outputs_held", bad_hold, 0);
      downstream_busy_in = 0;
      wait_dv(lat);
      chk("bp_release_latency", lat, 1);
      chk("bp_table", tbl, mk_tbl(1, 64, -1, 0));
      chk("bp_n", n, 64);
      @(posedge clk);
      #1;
      chk("bp_dv_once", dv, 0);

      // Saturation on the 8-bit instance; the 16-bit instance holds the true count.
      start_pair();
      for (int w = 0; w < 5; w++) begin
         send_word({64'h0, 64'h0, ones}, {64'h0, 64'h0, ones}, 1'b0, (w == 4));
      end
      wait_dv(lat);
      s_exp = '0;
      s_exp[SDW-1:0] = 8'hFF;
      chk("sat_dv", s_dv, 1);
      chk("sat_table", s_tbl, s_exp);
      chk("sat_n", s_n, 255);
      chk("sat_ovf", s_ovf, 1);
      chk("wide_table", tbl, mk_tbl(0, 320, -1, 0));
      chk("wide_n", n, 320);
      chk("wide_ovf", ovf, 0);
      @(posedge clk);
      #1;
      start_pair();
      send_word(vecs[2].a, vecs[2].b, vecs[2].cls, 1'b1);
      wait_dv(lat);
      chk("sat_next_ovf", s_ovf, 0);
      chk("sat_next_n", s_n, 32);
      @(posedge clk);
      #1;

      // Reset in the middle of a pair, with one word still in the pipeline.
      start_pair();
      send_word(vecs[0].a, vecs[0].b, 1'b0, 1'b0);
      send_word(vecs[0].a, vecs[0].b, 1'b0, 1'b0);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      chk("mid_rst_table", tbl, 0);
      chk("mid_rst_n", n, 0);
      chk("mid_rst_ready", ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_dv", dv, 0);
      start_pair();
      send_word({64'h0, 64'hF, 64'h0}, {64'h0, 64'hF, 64'h0}, 1'b0, 1'b1);
      wait_dv(lat);
      chk("post_rst_table", tbl, mk_tbl(4, 4, -1, 0));
      chk("post_rst_n", n, 4);
      @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
